gpio_bank: RTL and testbench
============================

// Module: gpio_bank
// PURPOSE
//  Parametrised memory-mapped GPIO peripheral for the MIPS SoC; generalises the fixed gpi_1/gpi_2/gpo_1/gpo_2 pins.
//  Provides NUM_IN synchronised input channels with rising-edge capture, NUM_OUT writable output channels and one
//  maskable interrupt. Sits on the data-memory bus beside dmem (we/a/wd/rd), decoded by the top-level address map.
// PARAMETERS
//  WIDTH        32  bits per channel and bus data width
//  NUM_IN       2   input channels, 1..4
//  NUM_OUT      2   output channels, 1..4
//  SYNC_STAGES  2   flops in each input synchroniser, >=2
// PORTS
//  clk   in   1                clock, all state on rising edge
//  rst   in   1                asynchronous reset, ACTIVE-LOW (asserted when 0)
//  we    in   1                bus write enable, sampled on clk rise
//  a     in   4                word index within block (byte addr [5:2])
//  wd    in   WIDTH            bus write data
//  rd    out  WIDTH            bus read data, combinational from a
//  gpi   in   NUM_IN*WIDTH     input pins, channel k = gpi[k*WIDTH +: WIDTH], asynchronous to clk
//  gpo   out  NUM_OUT*WIDTH    output pins, channel k = gpo[k*WIDTH +: WIDTH], driven straight from registers
//  irq   out  1                registered interrupt request
// BEHAVIOUR
//  Reset (rst=0, async): sync chains, prev regs, GPO regs, CAP regs, IEN = 0; gpo = 0, irq = 0; rd follows map.
//  Register map (a):
//   0..3   GPI[k]  RO  output of last sync stage; k>=NUM_IN reads 0
//   4..7   GPO[k]  RW  write loads register on the clock edge with we=1; k>=NUM_OUT reads 0, writes ignored
//   8..11  CAP[k]  RW1C  sticky rising-edge bits; write clears bits where wd=1; k>=NUM_IN reads 0
//   12     IEN     RW  bits [NUM_IN-1:0] enable irq per input channel; upper bits read 0, writes ignored
//   13..15 reserved: read 0, writes ignored. Writes to GPI ignored.
//  Synchroniser: per bit, SYNC_STAGES-flop chain; prev[k] <= sync_out[k] every cycle.
//  Edge detect: edge[k] = sync_out[k] & ~prev[k]; CAP[k] <= (CAP[k] & ~clr[k]) | edge[k].
//  Simultaneous set and W1C on the same bit in the same cycle: set wins (bit stays 1).
//  Latency (SYNC_STAGES=2): pin 0->1 stable before edge n: GPI reads 1 after edge n+1, CAP bit set after edge n+2,
//   irq high after edge n+3. Generally GPI at +S-1, CAP at +S, irq at +S+1 edges.
//  irq <= OR over k<NUM_IN of (IEN[k] & |CAP[k]); registered, one cycle after CAP/IEN change; drops one cycle
//   after the last enabling condition is cleared.
//  Falling edges not captured. Pins high when reset released are captured as rising edges (prev resets to 0).
//  GPO write: new value on gpo after the write edge (zero extra latency); read-back returns it same cycle after.
//  rd is purely combinational on a and register state; reading has no side effects (CAP clears only on write).
//  Reset asserted mid-operation clears everything immediately, irq drops without waiting for a clock.
// TESTING
//  1 Reset: rst=0 with gpi=all ones -> gpo=0, irq=0, rd(a=4)=0; release -> CAP[0]=FFFFFFFF after 2 edges.
//  2 GPO: write a=5 wd=DEADBEEF -> gpo[63:32]=DEADBEEF next cycle, rd(a=5)=DEADBEEF, gpo[31:0] unchanged.
//  3 Edge+irq: IEN=1, gpi[3:0] 0->5 -> GPI[0]=5 at +1, CAP[0]=5 at +2, irq=1 at +3; W1C wd=4 -> CAP[0]=1, irq stays 1;
//    W1C wd=1 -> CAP[0]=0, irq=0 one cycle later.
//  4 Set/clear collision: W1C wd=2 on the cycle CAP bit 1 is being set -> CAP[0] bit 1 stays 1.
//  5 Mask/reserved: IEN=0 with CAP[1]!=0 -> irq=0; write a=14, a=0, a=7 (NUM_OUT=2) -> no state change, reads 0 / GPI.
//  6 Mid-op reset: rst=0 while irq=1 -> irq, gpo, CAP, IEN all 0 before next clk rise.

Source files
------------

// File: rtl/gpio_bank_if.sv
// gpio_bank_if -- data-memory-side bus of the GPIO bank.
//   we  : write enable, sampled on the clock rise
//   a   : word index within the block (byte address [5:2])
//   wd  : write data
//   rd  : read data, combinational from a and block state
// master drives we/a/wd and receives rd; slave is the peripheral side.
interface gpio_bank_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [3:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output we, a, wd, input rd);
  modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank -- memory-mapped GPIO peripheral.
//   NUM_IN synchronised input channels with sticky rising-edge capture,
//   NUM_OUT writable output channels and one maskable, registered interrupt.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous reset, active low
//   bus  : gpio_bank_if.slave (we/a/wd in, rd out)
//   gpi  : input pins, channel k = gpi[k*WIDTH +: WIDTH], asynchronous to clk
//   gpo  : output pins, channel k = gpo[k*WIDTH +: WIDTH], straight from registers
//   irq  : registered interrupt request
// Map (a): 0..3 GPI (RO), 4..7 GPO (RW), 8..11 CAP (RW1C), 12 IEN, 13..15 reserved.

// One input channel: synchroniser chain, previous-value register and the
// sticky rising-edge capture register with write-1-to-clear.
module gpio_in_lane #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] cap
);
  // sync_q[0] samples the pin; sync_q[SYNC_STAGES-1] is the usable value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= '0;
      cap    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_out;
      // Edge term is OR-ed after the clear, so a set in the same cycle wins.
      cap    <= (cap & ~clr) | (sync_out & ~prev_q);
    end
  end
endmodule

module gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  gpio_bank_if.slave               bus,
  input  logic [NUM_IN*WIDTH-1:0]  gpi,
  output logic [NUM_OUT*WIDTH-1:0] gpo,
  output logic                     irq
);
  localparam logic [1:0] PG_GPI = 2'd0;
  localparam logic [1:0] PG_GPO = 2'd1;
  localparam logic [1:0] PG_CAP = 2'd2;
  localparam logic [1:0] PG_CTL = 2'd3;

  logic [1:0] pg, idx;
  assign pg  = bus.a[3:2];
  assign idx = bus.a[1:0];

  logic [NUM_IN-1:0][WIDTH-1:0]  sync_out, cap, clr;
  logic [NUM_OUT-1:0][WIDTH-1:0] gpo_q;
  logic [NUM_IN-1:0]             ien_q, cap_any;
  logic [WIDTH-1:0]              rd_d;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    assign clr[k] = (bus.we && pg == PG_CAP && idx == 2'(k)) ? bus.wd : '0;

    gpio_in_lane #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pin      (gpi[k*WIDTH +: WIDTH]),
      .clr      (clr[k]),
      .sync_out (sync_out[k]),
      .cap      (cap[k])
    );

    assign cap_any[k] = |cap[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpo_q <= '0;
      ien_q <= '0;
      irq   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (bus.we && pg == PG_GPO && idx == 2'(k)) gpo_q[k] <= bus.wd;
      if (bus.we && pg == PG_CTL && idx == 2'd0) ien_q <= bus.wd[NUM_IN-1:0];
      irq <= |(ien_q & cap_any);
    end
  end

  assign gpo = gpo_q;

  // Channels beyond NUM_IN/NUM_OUT and reserved words fall through to 0.
  always_comb begin
    rd_d = '0;
    case (pg)
      PG_GPI:  for (int k = 0; k < NUM_IN; k++)  if (idx == 2'(k)) rd_d = sync_out[k];
      PG_GPO:  for (int k = 0; k < NUM_OUT; k++) if (idx == 2'(k)) rd_d = gpo_q[k];
      PG_CAP:  for (int k = 0; k < NUM_IN; k++)  if (idx == 2'(k)) rd_d = cap[k];
      default: if (idx == 2'd0) rd_d = WIDTH'(ien_q);
    endcase
  end

  assign bus.rd = rd_d;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank -- directed scenarios followed by random bus/pin traffic,
// each cycle compared against a behavioural model of the register map.
module tb_gpio_bank;
  localparam int W  = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int S  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI*W-1:0] gpi;
  logic [NO*W-1:0] gpo;
  logic            irq;

  gpio_bank_if #(.WIDTH(W)) bus ();

  gpio_bank #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .gpi (gpi),
    .gpo (gpo),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pin samples taken at the last S edges (index 0 newest); the value
  // visible on GPI is the oldest of them. prev is the visible value one edge ago.
  logic [W-1:0] m_hist [S][NI];
  logic [W-1:0] m_prev [NI];
  logic [W-1:0] m_cap  [NI];
  logic [W-1:0] m_gpo  [NO];
  logic [W-1:0] m_ien;
  logic         m_irq;

  function automatic void model_reset();
    for (int i = 0; i < S; i++)
      for (int k = 0; k < NI; k++) m_hist[i][k] = '0;
    for (int k = 0; k < NI; k++) begin m_prev[k] = '0; m_cap[k] = '0; end
    for (int k = 0; k < NO; k++) m_gpo[k] = '0;
    m_ien = '0;
    m_irq = 1'b0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_edge();
    logic         any;
    logic [W-1:0] clr;
    int           ad;
    ad  = int'(bus.a);
    any = 1'b0;
    for (int k = 0; k < NI; k++) if (m_ien[k] && m_cap[k] != '0) any = 1'b1;
    for (int k = 0; k < NI; k++) begin
      clr       = (bus.we && ad == 8 + k) ? bus.wd : '0;
      m_cap[k]  = (m_cap[k] & ~clr) | (m_hist[S-1][k] & ~m_prev[k]);
      m_prev[k] = m_hist[S-1][k];
    end
    m_irq = any;
    if (bus.we && ad >= 4 && ad < 4 + NO) m_gpo[ad-4] = bus.wd;
    if (bus.we && ad == 12) m_ien = bus.wd & W'((1 << NI) - 1);
    for (int i = S - 1; i > 0; i--)
      for (int k = 0; k < NI; k++) m_hist[i][k] = m_hist[i-1][k];
    for (int k = 0; k < NI; k++) m_hist[0][k] = gpi[k*W +: W];
  endfunction

  function automatic logic [W-1:0] m_read(input logic [3:0] ad);
    int i;
    i = int'(ad[1:0]);
    case (ad[3:2])
      2'd0:    return (i < NI) ? m_hist[S-1][i] : '0;
      2'd1:    return (i < NO) ? m_gpo[i] : '0;
      2'd2:    return (i < NI) ? m_cap[i] : '0;
      default: return (ad == 4'd12) ? m_ien : '0;
    endcase
  endfunction

  function automatic logic [NO*W-1:0] m_gpo_vec();
    logic [NO*W-1:0] v;
    for (int k = 0; k < NO; k++) v[k*W +: W] = m_gpo[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model then DUT, then compare the pin-side outputs.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("gpo", 64'(gpo), 64'(m_gpo_vec()));
    chk("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [3:0] ad, input logic [W-1:0] d);
    bus.we = 1'b1; bus.a = ad; bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [3:0] ad);
    bus.we = 1'b0; bus.a = ad;
    #1;
    chk(tag, 64'(bus.rd), 64'(m_read(ad)));
  endtask

  initial begin
    bus.we = 1'b0; bus.a = 4'd4; bus.wd = '0;
    gpi = '1;
    model_reset();

    // Reset state with all pins high.
    #1 rst = 1'b0;
    #2;
    chk("rst_gpo", 64'(gpo), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_rd4", 64'(bus.rd), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(3);
    rdchk("rst_cap0", 4'd8);
    chk("rst_cap0_const", 64'(m_read(4'd8)), 64'hFFFF_FFFF);

    // GPO write and read-back.
    wr(4'd5, 32'hDEAD_BEEF);
    chk("gpo_hi", 64'(gpo[63:32]), 64'hDEAD_BEEF);
    chk("gpo_lo", 64'(gpo[31:0]), 64'h0);
    rdchk("gpo_rd5", 4'd5);

    // Edge capture, latency and irq.
    gpi = '0;
    idle(3);
    wr(4'd8, '1);
    wr(4'd9, '1);
    wr(4'd12, 32'h1);
    gpi = 64'h5;
    tick();
    tick();
    rdchk("gpi0_lat", 4'd0);
    chk("gpi0_val", 64'(bus.rd), 64'h5);
    tick();
    rdchk("cap0_lat", 4'd8);
    chk("cap0_val", 64'(bus.rd), 64'h5);
    chk("irq_not_yet", 64'(irq), 64'h0);
    tick();
    chk("irq_set", 64'(irq), 64'h1);
    wr(4'd8, 32'h4);
    rdchk("w1c_part", 4'd8);
    chk("w1c_part_val", 64'(bus.rd), 64'h1);
    chk("irq_hold", 64'(irq), 64'h1);
    wr(4'd8, 32'h1);
    rdchk("w1c_all", 4'd8);
    chk("irq_lag", 64'(irq), 64'h1);
    tick();
    chk("irq_drop", 64'(irq), 64'h0);

    // Set and clear of the same bit in the same cycle.
    gpi = 64'h7;
    tick();
    tick();
    wr(4'd8, 32'h2);
    rdchk("collide", 4'd8);
    chk("collide_val", 64'(bus.rd), 64'h2);

    // Masking and ignored writes.
    gpi = {32'h0000_00F0, 32'h7};
    idle(3);
    wr(4'd12, 32'h0);
    tick();
    chk("irq_masked", 64'(irq), 64'h0);
    rdchk("cap1", 4'd9);
    chk("cap1_val", 64'(bus.rd), 64'hF0);
    wr(4'd14, 32'h1234_5678);
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd7, 32'hA5A5_A5A5);
    chk("ign_gpo", 64'(gpo), {32'hDEAD_BEEF, 32'h0});
    rdchk("rsv14", 4'd14);
    rdchk("gpo7", 4'd7);
    rdchk("gpi0_ro", 4'd0);
    rdchk("ien_clr", 4'd12);

    // Reset while irq is high.
    wr(4'd12, 32'h3);
    tick();
    chk("pre_rst_irq", 64'(irq), 64'h1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_irq", 64'(irq), 64'h0);
    chk("mid_rst_gpo", 64'(gpo), 64'h0);
    rdchk("mid_rst_cap", 4'd8);
    rdchk("mid_rst_ien", 4'd12);
    rst = 1'b1;

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) gpi = {$urandom, $urandom};
      bus.we = 1'($urandom_range(0, 1));
      bus.a  = 4'($urandom_range(0, 15));
      bus.wd = $urandom;
      tick();
      rdchk("rnd_rd", 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
